// File: rtl/divider.sv
// RV32M iterative divider: DIV/DIVU/REM/REMU via restoring radix-2, one bit per clock.
// Divide-by-zero and signed overflow complete in a single cycle without iterating.
module divider (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_start,
  input  logic        i_kill,
  input  logic [31:0] i_in_a,
  input  logic [31:0] i_in_b,
  input  logic [2:0]  i_funct3,
  output logic        o_busy,
  output logic        o_valid,
  output logic [31:0] o_div_out
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  function automatic logic [31:0] magnitude(input logic signed [31:0] v, input logic is_signed);
    if (is_signed && v < 0) return 32'(-v);
    return 32'(v);
  endfunction

  function automatic logic [31:0] apply_sign(input logic [31:0] v, input logic neg);
    return neg ? (~v + 32'd1) : v;
  endfunction

  logic [1:0]  state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [32:0] rem_q, rem_d;
  logic [31:0] quo_q, quo_d;
  logic [31:0] dvsr_q, dvsr_d;
  logic        negq_q, negq_d;
  logic        negr_q, negr_d;
  logic        isrem_q, isrem_d;
  logic [31:0] out_q, out_d;

  logic signed [31:0] a_s, b_s;
  logic        op_signed, op_rem, accept;
  logic [33:0] shifted, diff;
  logic        ge;
  logic [32:0] rem_next;
  logic [31:0] quo_next;
  logic        unused_funct3;

  assign a_s           = i_in_a;
  assign b_s           = i_in_b;
  assign op_signed     = ~i_funct3[0];
  assign op_rem        = i_funct3[1];
  assign unused_funct3 = i_funct3[2];
  assign accept        = i_start && !i_kill && (state_q == S_IDLE || state_q == S_DONE);

  // One restoring step: shift {rem, quo} left, trial-subtract, keep if non-negative.
  assign shifted  = {rem_q, quo_q[31]};
  assign diff     = shifted - {2'b00, dvsr_q};
  assign ge       = ~diff[33];
  assign rem_next = ge ? diff[32:0] : shifted[32:0];
  assign quo_next = {quo_q[30:0], ge};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    dvsr_d  = dvsr_q;
    negq_d  = negq_q;
    negr_d  = negr_q;
    isrem_d = isrem_q;
    out_d   = out_q;
    if (i_kill) begin
      state_d = S_IDLE;
    end else if (accept) begin
      if (i_in_b == 32'd0) begin
        state_d = S_DONE;
        out_d   = op_rem ? i_in_a : 32'hFFFF_FFFF;
      end else if (op_signed && i_in_a == 32'h8000_0000 && i_in_b == 32'hFFFF_FFFF) begin
        state_d = S_DONE;
        out_d   = op_rem ? 32'h0000_0000 : 32'h8000_0000;
      end else begin
        state_d = S_CALC;
        cnt_d   = 6'd0;
        rem_d   = 33'd0;
        quo_d   = magnitude(a_s, op_signed);
        dvsr_d  = magnitude(b_s, op_signed);
        negq_d  = op_signed & (i_in_a[31] ^ i_in_b[31]);
        negr_d  = op_signed & i_in_a[31];
        isrem_d = op_rem;
      end
    end else begin
      case (state_q)
        S_CALC: begin
          rem_d = rem_next;
          quo_d = quo_next;
          cnt_d = cnt_q + 6'd1;
          if (cnt_q == 6'd31) begin
            state_d = S_DONE;
            out_d   = isrem_q ? apply_sign(rem_next[31:0], negr_q)
                              : apply_sign(quo_next, negq_q);
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= S_IDLE;
      cnt_q   <= 6'd0;
      rem_q   <= 33'd0;
      quo_q   <= 32'd0;
      dvsr_q  <= 32'd0;
      negq_q  <= 1'b0;
      negr_q  <= 1'b0;
      isrem_q <= 1'b0;
      out_q   <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      dvsr_q  <= dvsr_d;
      negq_q  <= negq_d;
      negr_q  <= negr_d;
      isrem_q <= isrem_d;
      out_q   <= out_d;
    end
  end

  assign o_busy    = (state_q == S_CALC);
  assign o_valid   = (state_q == S_DONE);
  assign o_div_out = out_q;

endmodule

// File: tb/tb_divider.sv
// Directed-vector bench for divider: latency, sign rules, special cases, kill, reset.
module tb_divider;
  logic        clk = 1'b0;
  logic        rst, start, kill;
  logic [31:0] a, b;
  logic [2:0]  f;
  logic        busy, valid;
  logic [31:0] dout;

  localparam logic [2:0] F_DIV = 3'b100, F_DIVU = 3'b101, F_REM = 3'b110, F_REMU = 3'b111;

  divider dut (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_kill(kill),
    .i_in_a(a), .i_in_b(b), .i_funct3(f),
    .o_busy(busy), .o_valid(valid), .o_div_out(dout)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Called at a negedge; the following posedge is the accepting edge.
  task automatic issue(input logic [2:0] fn, input logic [31:0] x, input logic [31:0] y);
    start = 1'b1; f = fn; a = x; b = y;
    @(negedge clk);
    start = 1'b0; f = 3'b000; a = 32'hDEAD_BEEF; b = 32'h1234_5678;
  endtask

  // lat = edges after the accepting edge before o_valid is seen.
  task automatic wait_valid(output int lat, output int nbusy);
    lat = 0; nbusy = 0;
    while (!valid && lat < 40) begin
      if (busy) nbusy++;
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic do_op(input string tag, input logic [2:0] fn, input logic [31:0] x,
                       input logic [31:0] y, input logic [31:0] expv, input int exp_lat);
    int lat, nb;
    @(negedge clk);
    issue(fn, x, y);
    wait_valid(lat, nb);
    chk({tag, " lat"}, lat, exp_lat);
    chk({tag, " res"}, dout, expv);
    chk({tag, " busy"}, nb, exp_lat);
    @(negedge clk);
    chk({tag, " vld_drop"}, {31'd0, valid}, 32'd0);
    chk({tag, " hold"}, dout, expv);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, required finish");
    $fatal(1);
  end

  initial begin
    int lat, nb, nv;
    rst = 1'b1; start = 1'b0; kill = 1'b0; a = '0; b = '0; f = '0;
    repeat (2) @(negedge clk);
    chk("rst busy", {31'd0, busy}, 32'd0);
    chk("rst valid", {31'd0, valid}, 32'd0);
    chk("rst out", dout, 32'd0);
    rst = 1'b0;

    do_op("divu 100/7", F_DIVU, 32'd100, 32'd7, 32'h0000_000E, 32);
    do_op("remu 100/7", F_REMU, 32'd100, 32'd7, 32'h0000_0002, 32);
    do_op("div -7/2",   F_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32);
    do_op("rem -7/2",   F_REM, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32);
    do_op("div 7/-2",   F_DIV, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32);
    do_op("rem 7/-2",   F_REM, 32'd7, 32'hFFFF_FFFE, 32'h0000_0001, 32);
    do_op("div -8/-3",  F_DIV, 32'hFFFF_FFF8, 32'hFFFF_FFFD, 32'h0000_0002, 32);
    do_op("rem -8/-3",  F_REM, 32'hFFFF_FFF8, 32'hFFFF_FFFD, 32'hFFFF_FFFE, 32);
    do_op("divu max/1", F_DIVU, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32);
    do_op("remu max/max-1", F_REMU, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 32);
    do_op("divu big/big", F_DIVU, 32'hF000_0000, 32'h8000_0001, 32'h0000_0001, 32);
    do_op("div 5/0",    F_DIV, 32'd5, 32'd0, 32'hFFFF_FFFF, 0);
    do_op("remu 5/0",   F_REMU, 32'd5, 32'd0, 32'h0000_0005, 0);
    do_op("rem -5/0",   F_REM, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, 0);
    do_op("div ovf",    F_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 0);
    do_op("rem ovf",    F_REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 0);
    do_op("divu 8000/ffff", F_DIVU, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32);

    // start pulse during CALC must be ignored
    @(negedge clk);
    issue(F_DIVU, 32'd1000, 32'd10);
    repeat (9) @(negedge clk);
    start = 1'b1; f = F_REMU; a = 32'd50; b = 32'd3;
    @(negedge clk);
    start = 1'b0;
    wait_valid(lat, nb);
    chk("ignore lat", lat, 22);
    chk("ignore busy", nb, 22);
    chk("ignore res", dout, 32'h0000_0064);

    // back-to-back: new start in the DONE cycle
    @(negedge clk);
    issue(F_DIVU, 32'd100, 32'd7);
    wait_valid(lat, nb);
    chk("b2b first", dout, 32'h0000_000E);
    issue(F_DIVU, 32'd1000, 32'd10);
    wait_valid(lat, nb);
    chk("b2b lat", lat, 32);
    chk("b2b res", dout, 32'h0000_0064);

    // kill mid-iteration
    @(negedge clk);
    issue(F_DIVU, 32'd77, 32'd7);
    repeat (4) @(negedge clk);
    kill = 1'b1;
    @(negedge clk);
    kill = 1'b0;
    chk("kill busy", {31'd0, busy}, 32'd0);
    nv = 0;
    repeat (40) begin
      if (valid) nv++;
      @(negedge clk);
    end
    chk("kill no valid", nv, 0);
    chk("kill hold out", dout, 32'h0000_0064);

    // kill beats simultaneous start
    start = 1'b1; kill = 1'b1; f = F_DIVU; a = 32'd9; b = 32'd3;
    @(negedge clk);
    start = 1'b0; kill = 1'b0;
    chk("kill+start busy", {31'd0, busy}, 32'd0);
    nv = 0;
    repeat (36) begin
      if (valid || busy) nv++;
      @(negedge clk);
    end
    chk("kill+start idle", nv, 0);
    chk("kill+start out", dout, 32'h0000_0064);

    // asynchronous reset mid-CALC
    issue(F_DIVU, 32'd100, 32'd7);
    repeat (19) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst busy", {31'd0, busy}, 32'd0);
    chk("arst valid", {31'd0, valid}, 32'd0);
    chk("arst out", dout, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    issue(F_DIVU, 32'd9, 32'd3);
    wait_valid(lat, nb);
    chk("post-rst lat", lat, 32);
    chk("post-rst res", dout, 32'h0000_0003);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/divider.md
DIVIDER -- requirements
Module: divider

Interface
REQ-001 Parameters: none; operand width fixed at 32.
REQ-002 i_clk  input  1  single clock; all state updates on its rising edge.
REQ-003 i_rst  input  1  asynchronous, active-high reset.
REQ-004 i_start  input  1  request pulse; operands and i_funct3 are sampled on the accepting edge.
REQ-005 i_kill  input  1  abort; pipeline flush.
REQ-006 i_in_a  input  32  dividend (rs1).
REQ-007 i_in_b  input  32  divisor (rs2).
REQ-008 i_funct3  input  3  RV32M op: 100 DIV, 101 DIVU, 110 REM, 111 REMU; only bits [1:0] are decoded (bit0 = unsigned, bit1 = remainder).
REQ-009 o_busy  output  1  high while an iteration is in progress.
REQ-010 o_valid  output  1  one-cycle pulse marking o_div_out as valid.
REQ-011 o_div_out  output  32  result register.

Function
REQ-012 States: IDLE, CALC, DONE; the encoding is free.
REQ-013 A start is accepted on an edge where i_start=1, i_kill=0 and the state is IDLE or DONE; i_start in CALC is ignored.
REQ-014 On accept with a normal case, the unit latches the operand magnitudes, the quotient sign (DIV: a[31]^b[31]), the remainder sign (a[31], signed ops only) and op bits; it clears the 6-bit counter and the 33-bit partial remainder, then enters CALC.
REQ-015 CALC performs one restoring radix-2 iteration per edge, MSB first:
- shift {rem, quo} left by 1;
- trial-subtract the divisor magnitude;
- keep the difference and set the quotient bit when the result is non-negative.
REQ-016 The edge completing iteration 32 moves the state to DONE and writes o_div_out with the quotient or remainder, negated when its sign flag is set.
REQ-017 Latency: accept at edge k leads to result and DONE at edge k+32; o_valid is high for exactly the cycle between edges k+32 and k+33.
REQ-018 Divisor zero (special case): at edge k go directly to DONE; result is 0xFFFFFFFF for DIV/DIVU and i_in_a for REM/REMU; o_valid is high in the following cycle.
REQ-019 Signed overflow (special case): DIV or REM with a=0x80000000 and b=0xFFFFFFFF goes directly to DONE; result is 0x80000000 for DIV and 0x00000000 for REM.
REQ-020 Sign rules: the quotient truncates toward zero; a nonzero remainder takes the sign of the dividend; unsigned ops never negate.
REQ-021 DONE lasts one cycle, then returns to IDLE unless a new start is accepted in that cycle (back-to-back operation).
REQ-022 o_busy = 1 only in CALC; o_valid = 1 only in DONE.
REQ-023 o_div_out holds its value from DONE until the next result write; it is not cleared on accept.
REQ-024 i_kill=1 in any state forces IDLE on the next edge; no o_valid is produced, o_div_out is unchanged, and i_kill has priority over a simultaneous i_start.
REQ-025 The counter does not wrap: CALC always exits after exactly 32 iterations.

Reset
REQ-026 While i_rst=1, asynchronously: state = IDLE, o_busy = 0, o_valid = 0, o_div_out = 0x00000000, and the counter and internal registers are cleared.
REQ-027 Reset asserted mid-CALC abandons the operation; no o_valid is produced after release.
REQ-028 The first edge after reset release may accept a start.

Verification
REQ-029 DIVU 100/7, start at edge k -> o_busy high for 32 cycles; o_valid at cycle k+32..k+33 with o_div_out = 0x0000000E; REMU 100/7 -> 0x00000002.
REQ-030 DIV -7/2 -> 0xFFFFFFFD; REM -7/2 -> 0xFFFFFFFF; DIV 7/-2 -> 0xFFFFFFFD; REM 7/-2 -> 0x00000001.
REQ-031 DIV 5/0 -> o_valid one cycle after accept with 0xFFFFFFFF; REMU 5/0 -> 0x00000005; DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM -> 0x00000000, one-cycle latency.
REQ-032 Start DIVU 1000/10, pulse i_start with other operands at iteration 10 -> result 0x00000064 at the original latency; start in the DONE cycle -> second result exactly 32 cycles later.
REQ-033 i_kill at iteration 5 -> IDLE next edge, no o_valid, previous o_div_out retained; i_start and i_kill in the same cycle -> no accept.
REQ-034 Assert i_rst mid-CALC (iteration 20) -> outputs zero immediately without a clock edge; after release, DIVU 9/3 -> 0x00000003 with normal latency.
